// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode 0 slave, MSB first, with tx holding register and sclk-domain byte interface
module spi_slave #(
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_di,
  output logic       spi_do,
  output logic       spi_do_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       rx_abort
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACTIVE       = 2'd1,
    WAIT_CS_HIGH = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  // Synchronizer chains: [0] first flop, [1] synchronized value, [2] edge-detect history.
  logic [2:0] clk_s;
  logic [2:0] cs_s;
  logic [1:0] di_s;
  // Marks the cs chain as holding real pin values rather than reset values.
  logic [1:0] sync_fill;

  logic       sck_rise;
  logic       sck_fall;
  logic       cs_rise;
  logic       cs_fall;

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold_data;
  logic       hold_full;

  logic       frame_start;
  logic       frame_end;
  logic       bit_rise;
  logic       bit_fall;
  logic       byte_done;
  logic       reload;

  logic       tx_fire;
  logic [7:0] load_byte;
  logic       underrun_now;

  assign sck_rise = clk_s[1] & ~clk_s[2];
  assign sck_fall = ~clk_s[1] & clk_s[2];
  assign cs_rise  = cs_s[1] & ~cs_s[2];
  assign cs_fall  = ~cs_s[1] & cs_s[2];

  assign tx_ready = ~hold_full;
  assign tx_fire  = tx_valid & tx_ready;

  // A queued byte wins; otherwise a same-cycle handshake is bypassed straight in; otherwise fill.
  assign load_byte    = hold_full ? hold_data : (tx_fire ? tx_data : DEFAULT_TX);
  assign underrun_now = reload & ~hold_full & ~tx_fire;

  // Bring the asynchronous SPI pins into the sclk domain.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s     <= 3'b000;
      cs_s      <= 3'b111;
      di_s      <= 2'b00;
      sync_fill <= 2'b00;
    end else begin
      clk_s     <= {clk_s[1:0], spi_clk};
      cs_s      <= {cs_s[1:0], spi_cs};
      di_s      <= {di_s[0], spi_di};
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // State register; reset parks in WAIT_CS_HIGH so a frame already in flight is never joined.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_CS_HIGH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cs_fall) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (cs_rise) state_nxt = IDLE;
      end
      WAIT_CS_HIGH: begin
        if (sync_fill[1] && cs_s[1]) state_nxt = IDLE;
      end
      default: state_nxt = WAIT_CS_HIGH;
    endcase
  end

  // Per-cycle control strobes; a cs rise overrides any SCK edge seen in the same cycle.
  always_comb begin
    frame_start = 1'b0;
    frame_end   = 1'b0;
    bit_rise    = 1'b0;
    bit_fall    = 1'b0;
    case (state)
      IDLE: begin
        frame_start = cs_fall;
      end
      ACTIVE: begin
        frame_end = cs_rise;
        bit_rise  = ~cs_rise & sck_rise;
        bit_fall  = ~cs_rise & sck_fall;
      end
      default: begin
        frame_start = 1'b0;
      end
    endcase
    byte_done = bit_rise & (bit_cnt == 3'd7);
    reload    = frame_start | byte_done;
  end

  // Holding register: filled by the handshake, emptied whenever its byte moves into the shifter.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (reload && hold_full) begin
      hold_full <= 1'b0;
    end else if (tx_fire && !reload) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end
  end

  // Transmit shifter and MISO: first bit driven at frame start, later bits on each SCK fall.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= 8'h00;
      spi_do      <= 1'b0;
      spi_do_en   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= underrun_now;
      if (frame_end) begin
        spi_do    <= 1'b0;
        spi_do_en <= 1'b0;
      end else if (reload) begin
        tx_shift <= load_byte;
        if (frame_start) begin
          spi_do    <= load_byte[7];
          spi_do_en <= 1'b1;
        end
      end else if (bit_fall) begin
        spi_do <= tx_shift[3'd7 - bit_cnt];
      end
    end
  end

  // Receive shifter, bit counter and the rx_valid / rx_abort pulses.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_abort <= 1'b0;
      if (frame_end) begin
        rx_abort <= (bit_cnt != 3'd0);
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
      end else if (frame_start) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 8'h00;
      end else if (bit_rise) begin
        rx_shift <= {rx_shift[6:0], di_s[1]};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {rx_shift[6:0], di_s[1]};
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard testbench for spi_slave
module tb_spi_slave;

  localparam int HALF = 6;

  logic       sclk;
  logic       rst_n;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_di;
  logic       spi_do;
  logic       spi_do_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       rx_abort;

  int tests = 0;
  int fails = 0;
  int cnt_rxv = 0;
  int cnt_und = 0;
  int cnt_abort = 0;
  int quiet_err = 0;
  bit watch_quiet = 1'b0;
  logic [7:0] exp_rx[$];

  spi_slave #(.DEFAULT_TX(8'hFF)) dut (
    .sclk(sclk),
    .rst_n(rst_n),
    .spi_clk(spi_clk),
    .spi_cs(spi_cs),
    .spi_di(spi_di),
    .spi_do(spi_do),
    .spi_do_en(spi_do_en),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_underrun(tx_underrun),
    .rx_abort(rx_abort)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Scoreboard side: every rx_valid pops the byte the master sent.
  always @(negedge sclk) begin
    logic [7:0] e;
    if (rx_valid === 1'b1) begin
      cnt_rxv++;
      tests++;
      if (exp_rx.size() == 0) begin
        fails++;
        $display("FAIL rx_unexpected: got %h, required no rx_valid", rx_data);
      end else begin
        e = exp_rx.pop_front();
        if (rx_data !== e) begin
          fails++;
          $display("FAIL rx_byte: got %h, required %h", rx_data, e);
        end
      end
      if (rx_abort === 1'b1) begin
        tests++;
        fails++;
        $display("FAIL rx_valid_with_abort: got both 1, required not simultaneous");
      end
    end
    if (tx_underrun === 1'b1) cnt_und++;
    if (rx_abort === 1'b1) cnt_abort++;
    if (watch_quiet && (spi_do !== 1'b0 || spi_do_en !== 1'b0 || rx_valid !== 1'b0 ||
                        tx_underrun !== 1'b0 || rx_abort !== 1'b0 || tx_ready !== 1'b1))
      quiet_err++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time limit, required completion");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic queue_tx(input logic [7:0] b);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge sclk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL tx_ready_timeout: got %b, required 1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge sclk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_high();
    wait_cyc(HALF);
    spi_cs = 1'b1;
    wait_cyc(HALF);
  endtask

  // Master shifts nbits MSB first; MISO sampled just before each rising SCK.
  task automatic spi_bits(input logic [7:0] mosi, input int nbits, input int inject_bit,
                          input logic [7:0] inj_data, output logic [7:0] miso,
                          output int und_before_last);
    miso = 8'h00;
    und_before_last = cnt_und;
    for (int i = 0; i < nbits; i++) begin
      spi_di = mosi[7-i];
      wait_cyc(HALF);
      miso[7-i] = spi_do;
      if (i == nbits - 1) und_before_last = cnt_und;
      spi_clk = 1'b1;
      if (i == inject_bit) begin
        // Two sync flops then edge detect: the reload cycle is the third sclk edge after the rise.
        wait_cyc(2);
        tests++;
        if (tx_ready !== 1'b1) begin
          fails++;
          $display("FAIL bypass_ready: got %b, required 1", tx_ready);
        end
        tx_data  = inj_data;
        tx_valid = 1'b1;
        wait_cyc(1);
        tx_valid = 1'b0;
        wait_cyc(HALF - 3);
      end else begin
        wait_cyc(HALF);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    tests++;
    if (spi_do !== 1'b0 || spi_do_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_miso: got do=%b en=%b, required 0 0", spi_do, spi_do_en);
    end
    tests++;
    if (tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_tx_ready: got %b, required 1", tx_ready);
    end
    tests++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_rx: got data=%h valid=%b, required 00 0", rx_data, rx_valid);
    end
    tests++;
    if (tx_underrun !== 1'b0 || rx_abort !== 1'b0) begin
      fails++;
      $display("FAIL reset_pulses: got und=%b abort=%b, required 0 0", tx_underrun, rx_abort);
    end
    rst_n = 1'b1;
    wait_cyc(HALF);
    tests++;
    if (spi_do_en !== 1'b0 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL post_reset: got en=%b ready=%b, required 0 1", spi_do_en, tx_ready);
    end
  endtask

  task automatic test_idle_clocks();
    int r0, u0;
    r0 = cnt_rxv;
    u0 = cnt_und;
    for (int i = 0; i < 9; i++) begin
      spi_di  = i[0];
      spi_clk = 1'b1;
      wait_cyc(HALF);
      spi_clk = 1'b0;
      wait_cyc(HALF);
    end
    tests++;
    if (cnt_rxv != r0 || cnt_und != u0 || spi_do_en !== 1'b0) begin
      fails++;
      $display("FAIL idle_clocks: got rxv=%0d und=%0d en=%b, required 0 0 0",
               cnt_rxv - r0, cnt_und - u0, spi_do_en);
    end
  endtask

  task automatic test_basic();
    int r0, u0, a0, ub;
    logic [7:0] m;
    r0 = cnt_rxv;
    u0 = cnt_und;
    a0 = cnt_abort;
    queue_tx(8'hA5);
    tests++;
    if (tx_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_hold_full: got %b, required 0", tx_ready);
    end
    cs_low();
    tests++;
    if (spi_do_en !== 1'b1 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_entry: got en=%b ready=%b, required 1 1", spi_do_en, tx_ready);
    end
    exp_rx.push_back(8'h3C);
    spi_bits(8'h3C, 8, -1, 8'h00, m, ub);
    tests++;
    if (m !== 8'hA5) begin
      fails++;
      $display("FAIL basic_miso: got %h, required a5", m);
    end
    tests++;
    if (ub != u0) begin
      fails++;
      $display("FAIL basic_underrun: got %0d, required 0", ub - u0);
    end
    cs_high();
    tests++;
    if (cnt_rxv - r0 != 1 || cnt_abort != a0) begin
      fails++;
      $display("FAIL basic_pulses: got rxv=%0d abort=%0d, required 1 0", cnt_rxv - r0, cnt_abort - a0);
    end
    tests++;
    if (rx_data !== 8'h3C || spi_do !== 1'b0 || spi_do_en !== 1'b0) begin
      fails++;
      $display("FAIL basic_end: got rx=%h do=%b en=%b, required 3c 0 0", rx_data, spi_do, spi_do_en);
    end
  endtask

  task automatic test_underrun();
    int r0, u0, a0, ub1, ub2;
    logic [7:0] m1, m2;
    r0 = cnt_rxv;
    u0 = cnt_und;
    a0 = cnt_abort;
    cs_low();
    exp_rx.push_back(8'h01);
    spi_bits(8'h01, 8, -1, 8'h00, m1, ub1);
    exp_rx.push_back(8'h02);
    spi_bits(8'h02, 8, -1, 8'h00, m2, ub2);
    cs_high();
    tests++;
    if (m1 !== 8'hFF || m2 !== 8'hFF) begin
      fails++;
      $display("FAIL underrun_miso: got %h %h, required ff ff", m1, m2);
    end
    tests++;
    if (ub1 - u0 != 1 || ub2 - u0 != 2) begin
      fails++;
      $display("FAIL underrun_count: got %0d %0d, required 1 2", ub1 - u0, ub2 - u0);
    end
    tests++;
    if (cnt_rxv - r0 != 2 || cnt_abort != a0 || rx_data !== 8'h02) begin
      fails++;
      $display("FAIL underrun_rx: got rxv=%0d abort=%0d rx=%h, required 2 0 02",
               cnt_rxv - r0, cnt_abort - a0, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int u0, ub1, ub2;
    logic [7:0] m1, m2;
    u0 = cnt_und;
    queue_tx(8'h11);
    cs_low();
    exp_rx.push_back(8'h55);
    spi_bits(8'h55, 8, 7, 8'h22, m1, ub1);
    tests++;
    if (tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL bypass_hold_empty: got %b, required 1", tx_ready);
    end
    exp_rx.push_back(8'hAA);
    spi_bits(8'hAA, 8, -1, 8'h00, m2, ub2);
    cs_high();
    tests++;
    if (m1 !== 8'h11 || m2 !== 8'h22) begin
      fails++;
      $display("FAIL bypass_miso: got %h %h, required 11 22", m1, m2);
    end
    tests++;
    if (ub2 != u0 || tx_ready !== 1'b1) begin
      fails++;
      $display("FAIL bypass_underrun: got und=%0d ready=%b, required 0 1", ub2 - u0, tx_ready);
    end
  endtask

  task automatic test_abort();
    int r0, a0, ub;
    logic [7:0] m1, m2;
    r0 = cnt_rxv;
    a0 = cnt_abort;
    queue_tx(8'hC3);
    cs_low();
    queue_tx(8'h3E);
    spi_bits(8'hF0, 5, -1, 8'h00, m1, ub);
    cs_high();
    tests++;
    if ((m1 & 8'hF8) !== 8'hC0) begin
      fails++;
      $display("FAIL abort_partial_miso: got %h, required c0 in top 5 bits", m1 & 8'hF8);
    end
    tests++;
    if (cnt_abort - a0 != 1 || cnt_rxv != r0) begin
      fails++;
      $display("FAIL abort_pulses: got abort=%0d rxv=%0d, required 1 0", cnt_abort - a0, cnt_rxv - r0);
    end
    tests++;
    if (rx_data !== 8'hAA || tx_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_retain: got rx=%h ready=%b, required aa 0", rx_data, tx_ready);
    end
    cs_low();
    exp_rx.push_back(8'h96);
    spi_bits(8'h96, 8, -1, 8'h00, m2, ub);
    cs_high();
    tests++;
    if (m2 !== 8'h3E || cnt_rxv - r0 != 1 || cnt_abort - a0 != 1) begin
      fails++;
      $display("FAIL abort_next_frame: got miso=%h rxv=%0d abort=%0d, required 3e 1 1",
               m2, cnt_rxv - r0, cnt_abort - a0);
    end
  endtask

  task automatic test_reset_mid();
    int r0, u0, ub;
    logic [7:0] m;
    cs_low();
    spi_bits(8'hA5, 3, -1, 8'h00, m, ub);
    rst_n = 1'b0;
    #1;
    tests++;
    if (spi_do_en !== 1'b0 || spi_do !== 1'b0 || tx_ready !== 1'b1 || rx_data !== 8'h00) begin
      fails++;
      $display("FAIL midreset_async: got en=%b do=%b ready=%b rx=%h, required 0 0 1 00",
               spi_do_en, spi_do, tx_ready, rx_data);
    end
    wait_cyc(2);
    r0 = cnt_rxv;
    u0 = cnt_und;
    quiet_err = 0;
    watch_quiet = 1'b1;
    rst_n = 1'b1;
    spi_bits(8'hFF, 8, -1, 8'h00, m, ub);
    spi_bits(8'h00, 8, -1, 8'h00, m, ub);
    wait_cyc(HALF);
    watch_quiet = 1'b0;
    tests++;
    if (quiet_err != 0 || cnt_rxv != r0 || cnt_und != u0) begin
      fails++;
      $display("FAIL midreset_quiet: got bad_cycles=%0d rxv=%0d und=%0d, required 0 0 0",
               quiet_err, cnt_rxv - r0, cnt_und - u0);
    end
    cs_high();
    cs_low();
    exp_rx.push_back(8'h69);
    spi_bits(8'h69, 8, -1, 8'h00, m, ub);
    cs_high();
    tests++;
    if (m !== 8'hFF || cnt_rxv - r0 != 1 || rx_data !== 8'h69) begin
      fails++;
      $display("FAIL midreset_rejoin: got miso=%h rxv=%0d rx=%h, required ff 1 69",
               m, cnt_rxv - r0, rx_data);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    spi_clk  = 1'b0;
    spi_cs   = 1'b1;
    spi_di   = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    test_reset();
    test_idle_clocks();
    test_basic();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    wait_cyc(4);
    tests++;
    if (exp_rx.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_rx.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
